// File: rtl/grid_cell_picker.sv
// grid_cell_picker: maps the mouse position onto the board grid. It reports the
// hovered cell every cycle and turns a left-button press on a cell into a
// one-shot click event that is held until the consumer acknowledges it.
module grid_cell_picker #(
  parameter int unsigned X_POS     = 0,
  parameter int unsigned Y_POS     = 0,
  parameter int unsigned CELL_LOG2 = 5,
  parameter int unsigned CELLS     = 12,
  parameter int unsigned BORDER    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  input  logic        left,
  input  logic        cell_ack,
  output logic        hover_valid,
  output logic [3:0]  hover_x,
  output logic [3:0]  hover_y,
  output logic        click_valid,
  output logic [3:0]  click_x,
  output logic [3:0]  click_y
);

  localparam logic [11:0]          X_OFF     = 12'(X_POS);
  localparam logic [11:0]          Y_OFF     = 12'(Y_POS);
  localparam logic [11:0]          GRID_SPAN = 12'(CELLS << CELL_LOG2);
  localparam logic [CELL_LOG2-1:0] BORDER_W  = BORDER[CELL_LOG2-1:0];

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PENDING  = 2'd1,
    WAIT_REL = 2'd2
  } state_t;

  // stage 1: grid-relative offsets and button history
  logic [11:0] dx_q, dx_d, dy_q, dy_d;
  logic        left_s1_q, left_s1_d, left_s1d_q, left_s1d_d;
  // stage 2: hover outputs
  logic        hover_valid_q, hover_valid_d;
  logic [3:0]  hover_x_q, hover_x_d, hover_y_q, hover_y_d;
  // click event
  state_t      state_q, state_d;
  logic        click_valid_q, click_valid_d;
  logic [3:0]  click_x_q, click_x_d, click_y_q, click_y_d;

  logic        hit;
  logic        press;
  logic [3:0]  idx_x, idx_y;

  // pointer pipeline: subtract the grid origin, classify cell/border, register hover
  always_comb begin
    dx_d       = xpos - X_OFF;
    dy_d       = ypos - Y_OFF;
    left_s1_d  = left;
    left_s1d_d = left_s1_q;

    // positions left/above the grid wrap to large values and fail the span test
    hit   = (dx_q < GRID_SPAN) && (dx_q[CELL_LOG2-1:0] >= BORDER_W) &&
            (dy_q < GRID_SPAN) && (dy_q[CELL_LOG2-1:0] >= BORDER_W);
    idx_x = dx_q[CELL_LOG2 +: 4];
    idx_y = dy_q[CELL_LOG2 +: 4];
    press = left_s1_q & ~left_s1d_q;

    hover_valid_d = hit;
    hover_x_d     = hit ? idx_x : '0;
    hover_y_d     = hit ? idx_y : '0;
  end

  // click FSM next state; click_valid trails the state by one register so the
  // event shows 3 clocks after the press, but drops on the cycle after the ack
  always_comb begin
    state_d       = state_q;
    click_valid_d = 1'b0;
    click_x_d     = click_x_q;
    click_y_d     = click_y_q;
    case (state_q)
      IDLE: begin
        if (press && hit) begin
          state_d   = PENDING;
          click_x_d = idx_x;
          click_y_d = idx_y;
        end
      end
      PENDING: begin
        if (click_valid_q && cell_ack) begin
          state_d = left_s1_q ? WAIT_REL : IDLE;
        end else begin
          click_valid_d = 1'b1;
        end
      end
      WAIT_REL: begin
        if (!left_s1_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // pipeline and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      dx_q          <= '0;
      dy_q          <= '0;
      left_s1_q     <= 1'b0;
      left_s1d_q    <= 1'b0;
      hover_valid_q <= 1'b0;
      hover_x_q     <= '0;
      hover_y_q     <= '0;
      click_valid_q <= 1'b0;
      click_x_q     <= '0;
      click_y_q     <= '0;
    end else begin
      dx_q          <= dx_d;
      dy_q          <= dy_d;
      left_s1_q     <= left_s1_d;
      left_s1d_q    <= left_s1d_d;
      hover_valid_q <= hover_valid_d;
      hover_x_q     <= hover_x_d;
      hover_y_q     <= hover_y_d;
      click_valid_q <= click_valid_d;
      click_x_q     <= click_x_d;
      click_y_q     <= click_y_d;
    end
  end

  assign hover_valid = hover_valid_q;
  assign hover_x     = hover_x_q;
  assign hover_y     = hover_y_q;
  assign click_valid = click_valid_q;
  assign click_x     = click_x_q;
  assign click_y     = click_y_q;

endmodule

// File: tb/tb_grid_cell_picker.sv
// Bench for grid_cell_picker with the grid placed at (64,32).
module tb_grid_cell_picker;

  localparam int unsigned XP    = 64;
  localparam int unsigned YP    = 32;
  localparam int unsigned PITCH = 32;
  localparam int unsigned NCELL = 12;
  localparam int unsigned BDR   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] xpos, ypos;
  logic        left, cell_ack;
  logic        hover_valid, click_valid;
  logic [3:0]  hover_x, hover_y, click_x, click_y;

  int checks   = 0;
  int failures = 0;

  grid_cell_picker #(.X_POS(XP), .Y_POS(YP)) dut (
    .clk(clk), .rst(rst), .xpos(xpos), .ypos(ypos), .left(left), .cell_ack(cell_ack),
    .hover_valid(hover_valid), .hover_x(hover_x), .hover_y(hover_y),
    .click_valid(click_valid), .click_x(click_x), .click_y(click_y)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic bit m_hit(int unsigned d);
    return (d < NCELL * PITCH) && ((d % PITCH) >= BDR);
  endfunction

  function automatic int unsigned m_off(logic [11:0] p, int unsigned org);
    return (int'(p) + 4096 - org) % 4096;
  endfunction

  // owner of the click channel: free, event accepted (not shown yet),
  // event shown to the consumer, or waiting for the button to be released
  localparam int M_FREE = 0, M_ACCEPTED = 1, M_SHOWN = 2, M_HELD = 3;
  int          m_owner;
  int unsigned m_dx_prev, m_dy_prev;
  bit          m_left_prev, m_left_prev2;
  bit          exp_hv, exp_cv;
  int unsigned exp_hx, exp_hy, exp_cx, exp_cy;

  always @(posedge clk) begin
    if (rst) begin
      m_owner = M_FREE;
      m_dx_prev = 0; m_dy_prev = 0;
      m_left_prev = 0; m_left_prev2 = 0;
      exp_hv = 0; exp_hx = 0; exp_hy = 0;
      exp_cv = 0; exp_cx = 0; exp_cy = 0;
    end else begin
      bit on_cell;
      bit rose;
      on_cell = m_hit(m_dx_prev) && m_hit(m_dy_prev);
      rose    = m_left_prev && !m_left_prev2;
      exp_hv  = on_cell;
      exp_hx  = on_cell ? (m_dx_prev / PITCH) % 16 : 0;
      exp_hy  = on_cell ? (m_dy_prev / PITCH) % 16 : 0;
      if (m_owner == M_FREE) begin
        if (rose && on_cell) begin
          m_owner = M_ACCEPTED;
          exp_cx  = (m_dx_prev / PITCH) % 16;
          exp_cy  = (m_dy_prev / PITCH) % 16;
        end
      end else if (m_owner == M_ACCEPTED) begin
        exp_cv  = 1;
        m_owner = M_SHOWN;
      end else if (m_owner == M_SHOWN) begin
        if (cell_ack) begin
          exp_cv  = 0;
          m_owner = m_left_prev ? M_HELD : M_FREE;
        end
      end else begin
        if (!m_left_prev) m_owner = M_FREE;
      end
      m_left_prev2 = m_left_prev;
      m_left_prev  = left;
      m_dx_prev    = m_off(xpos, XP);
      m_dy_prev    = m_off(ypos, YP);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_pos(input int x, input int y);
    xpos = 12'(x);
    ypos = 12'(y);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1; left = 0; cell_ack = 0; set_pos(170, 197);
    cyc(3);
    checks++;
    if ({hover_valid, hover_x, hover_y, click_valid, click_x, click_y} !== 18'd0) begin
      failures++;
      $display("FAIL reset_outputs got hv=%b hx=%0d hy=%0d cv=%b cx=%0d cy=%0d want all 0",
               hover_valid, hover_x, hover_y, click_valid, click_x, click_y);
    end
    rst = 0;
  endtask

  task automatic test_hover;
    set_pos(170, 197);
    cyc(2);
    checks++;
    if (hover_valid !== 1'b1 || hover_x !== 4'd3 || hover_y !== 4'd5) begin
      failures++;
      $display("FAIL hover_cell got v=%b x=%0d y=%0d want v=1 x=3 y=5", hover_valid, hover_x, hover_y);
    end
    set_pos(63, 197);
    cyc(1);
    checks++;
    if (hover_valid !== 1'b1 || hover_x !== 4'd3) begin
      failures++;
      $display("FAIL hover_latency got v=%b x=%0d want v=1 x=3 (old value one clk later)", hover_valid, hover_x);
    end
    cyc(1);
    checks++;
    if (hover_valid !== 1'b0 || hover_x !== 4'd0 || hover_y !== 4'd0) begin
      failures++;
      $display("FAIL hover_left_of_grid got v=%b x=%0d y=%0d want 0 0 0", hover_valid, hover_x, hover_y);
    end
  endtask

  task automatic test_borders;
    int px[4] = '{161, 448, 450, 447};
    int py[4] = '{197, 100, 100, 100};
    bit ev[4] = '{0, 0, 0, 1};
    int ex[4] = '{0, 0, 0, 11};
    int ey[4] = '{0, 0, 0, 2};
    for (int i = 0; i < 4; i++) begin
      set_pos(px[i], py[i]);
      cyc(2);
      checks++;
      if (hover_valid !== ev[i] || hover_x !== 4'(ex[i]) || hover_y !== 4'(ey[i])) begin
        failures++;
        $display("FAIL border_%0d at (%0d,%0d) got v=%b x=%0d y=%0d want v=%b x=%0d y=%0d",
                 i, px[i], py[i], hover_valid, hover_x, hover_y, ev[i], ex[i], ey[i]);
      end
    end
  endtask

  task automatic test_click;
    set_pos(170, 197); left = 0;
    cyc(3);
    left = 1;
    cyc(2);
    checks++;
    if (click_valid !== 1'b0) begin
      failures++;
      $display("FAIL click_early got cv=%b want 0 two clk after press", click_valid);
    end
    cyc(1);
    checks++;
    if (click_valid !== 1'b1 || click_x !== 4'd3 || click_y !== 4'd5) begin
      failures++;
      $display("FAIL click_rise got cv=%b x=%0d y=%0d want 1 3 5", click_valid, click_x, click_y);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      checks++;
      if (click_valid !== 1'b1) begin
        failures++;
        $display("FAIL click_hold_%0d got cv=%b want 1", i, click_valid);
      end
    end
    cell_ack = 1;
    cyc(1);
    cell_ack = 0;
    checks++;
    if (click_valid !== 1'b0) begin
      failures++;
      $display("FAIL click_ack got cv=%b want 0 one clk after ack", click_valid);
    end
    cell_ack = 1;
    cyc(4);
    cell_ack = 0;
    checks++;
    if (click_valid !== 1'b0) begin
      failures++;
      $display("FAIL click_wait_release got cv=%b want 0 while button held", click_valid);
    end
    left = 0;
    cyc(3);
    left = 1;
    cyc(3);
    checks++;
    if (click_valid !== 1'b1) begin
      failures++;
      $display("FAIL click_after_release got cv=%b want 1", click_valid);
    end
    cell_ack = 1; cyc(1); cell_ack = 0;
    left = 0; cyc(3);
  endtask

  task automatic test_no_ack;
    set_pos(170, 197);
    left = 1; cyc(3);
    left = 0; cyc(2);
    set_pos(400, 400); cyc(2);
    left = 1; cyc(4);
    checks++;
    if (click_valid !== 1'b1 || click_x !== 4'd3 || click_y !== 4'd5) begin
      failures++;
      $display("FAIL no_ack_frozen got cv=%b x=%0d y=%0d want 1 3 5", click_valid, click_x, click_y);
    end
    cell_ack = 1; cyc(1); cell_ack = 0;
    left = 0; cyc(3);
    checks++;
    if (click_valid !== 1'b0) begin
      failures++;
      $display("FAIL no_ack_cleared got cv=%b want 0", click_valid);
    end
  endtask

  task automatic test_border_click;
    set_pos(161, 197); cyc(2);
    left = 1;
    for (int i = 0; i < 6; i++) begin
      cyc(1);
      checks++;
      if (click_valid !== 1'b0) begin
        failures++;
        $display("FAIL border_press_%0d got cv=%b want 0", i, click_valid);
      end
    end
    set_pos(170, 197);
    for (int i = 0; i < 6; i++) begin
      cyc(1);
      checks++;
      if (click_valid !== 1'b0) begin
        failures++;
        $display("FAIL held_move_%0d got cv=%b want 0", i, click_valid);
      end
    end
    left = 0; cyc(2);
    left = 1; cyc(3);
    checks++;
    if (click_valid !== 1'b1 || click_x !== 4'd3 || click_y !== 4'd5) begin
      failures++;
      $display("FAIL repress_click got cv=%b x=%0d y=%0d want 1 3 5", click_valid, click_x, click_y);
    end
    cell_ack = 1; cyc(1); cell_ack = 0;
    left = 0; cyc(3);
  endtask

  task automatic test_back_to_back;
    set_pos(170, 197);
    left = 1; cyc(3);
    left = 0; cyc(2);
    left = 1; cyc(1);
    cell_ack = 1; cyc(1); cell_ack = 0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (click_valid !== 1'b0) begin
        failures++;
        $display("FAIL ack_beats_press_%0d got cv=%b want 0", i, click_valid);
      end
      cyc(1);
    end
    left = 0; cyc(3);
  endtask

  task automatic test_reset_pending;
    set_pos(170, 197);
    left = 1; cyc(3);
    left = 0; cyc(1);
    rst = 1; cyc(1); rst = 0;
    checks++;
    if ({hover_valid, hover_x, hover_y, click_valid, click_x, click_y} !== 18'd0) begin
      failures++;
      $display("FAIL reset_pending got hv=%b hx=%0d hy=%0d cv=%b cx=%0d cy=%0d want all 0",
               hover_valid, hover_x, hover_y, click_valid, click_x, click_y);
    end
    set_pos(96 + 2, 64 + 2); cyc(2);
    left = 1; cyc(3);
    checks++;
    if (click_valid !== 1'b1 || click_x !== 4'd1 || click_y !== 4'd1) begin
      failures++;
      $display("FAIL click_after_reset got cv=%b x=%0d y=%0d want 1 1 1", click_valid, click_x, click_y);
    end
    cell_ack = 1; cyc(1); cell_ack = 0;
    left = 0; cyc(3);
    // button held across reset release counts as a fresh press
    set_pos(170, 197); left = 1;
    rst = 1; cyc(2); rst = 0;
    cyc(2);
    checks++;
    if (click_valid !== 1'b0) begin
      failures++;
      $display("FAIL held_reset_early got cv=%b want 0", click_valid);
    end
    cyc(1);
    checks++;
    if (click_valid !== 1'b1 || click_x !== 4'd3 || click_y !== 4'd5) begin
      failures++;
      $display("FAIL held_reset_click got cv=%b x=%0d y=%0d want 1 3 5", click_valid, click_x, click_y);
    end
    cell_ack = 1; cyc(1); cell_ack = 0;
    left = 0; cyc(3);
  endtask

  task automatic test_random;
    int bad = 0;
    for (int i = 0; i < 3000; i++) begin
      cyc(1);
      checks++;
      if (hover_valid !== exp_hv || hover_x !== 4'(exp_hx) || hover_y !== 4'(exp_hy) ||
          click_valid !== exp_cv ||
          (exp_cv && (click_x !== 4'(exp_cx) || click_y !== 4'(exp_cy)))) begin
        failures++;
        bad++;
        if (bad <= 10)
          $display("FAIL random_cycle_%0d got hv=%b hx=%0d hy=%0d cv=%b cx=%0d cy=%0d want hv=%b hx=%0d hy=%0d cv=%b cx=%0d cy=%0d",
                   i, hover_valid, hover_x, hover_y, click_valid, click_x, click_y,
                   exp_hv, exp_hx, exp_hy, exp_cv, exp_cx, exp_cy);
      end
      if ($urandom_range(0, 3) == 0) set_pos($urandom_range(40, 480), $urandom_range(10, 440));
      if ($urandom_range(0, 5) == 0) left = ~left;
      cell_ack = ($urandom_range(0, 2) == 0);
      rst      = ($urandom_range(0, 199) == 0);
    end
    rst = 0; cell_ack = 0; left = 0;
    cyc(3);
  endtask

  initial begin
    test_reset();
    test_hover();
    test_borders();
    test_click();
    test_no_ack();
    test_border_click();
    test_back_to_back();
    test_reset_pending();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
